// File: rtl/fir_pkg.sv
// Shared constants and state encoding for the FIR configuration sequencer.
package fir_pkg;

  localparam logic [31:0] ADDR_AP_CTRL  = 32'h00;
  localparam logic [31:0] ADDR_DATA_LEN = 32'h10;
  localparam logic [31:0] ADDR_TAP_BASE = 32'h20;

  localparam int AP_START_BIT = 0;
  localparam int AP_DONE_BIT  = 1;
  localparam int AP_IDLE_BIT  = 2;

  typedef enum logic [3:0] {
    IDLE,
    WR_LEN,
    TAP_GET,
    TAP_WR,
    WR_START,
    POLL_AR,
    POLL_R,
    POLL_WAIT,
    DONE,
    ERR
  } seq_state_t;

endpackage

// File: rtl/fir_cfg_seq_axil_wr_ch.sv
// Single AXI-Lite write issuer: aw and w are raised together and retire
// independently; wr_done fires on the edge where the second one is accepted.
module axil_wr_ch #(
  parameter int AW = 12,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] data,
  output logic          awvalid,
  input  logic          awready,
  output logic [AW-1:0] awaddr,
  output logic          wvalid,
  input  logic          wready,
  output logic [DW-1:0] wdata,
  output logic          pend,
  output logic          wr_done
);

  logic aw_acc, w_acc;
  logic aw_ok, w_ok;

  // A channel counts as accepted either from an earlier edge or on this one,
  // so both readies landing together completes in a single edge.
  assign aw_ok   = aw_acc | (awvalid & awready);
  assign w_ok    = w_acc  | (wvalid  & wready);
  assign wr_done = pend & aw_ok & w_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      awvalid <= 1'b0;
      wvalid  <= 1'b0;
      awaddr  <= '0;
      wdata   <= '0;
      aw_acc  <= 1'b0;
      w_acc   <= 1'b0;
      pend    <= 1'b0;
    end else if (start) begin
      awvalid <= 1'b1;
      wvalid  <= 1'b1;
      awaddr  <= addr;
      wdata   <= data;
      aw_acc  <= 1'b0;
      w_acc   <= 1'b0;
      pend    <= 1'b1;
    end else begin
      if (awvalid && awready) begin
        awvalid <= 1'b0;
        aw_acc  <= 1'b1;
      end
      if (wvalid && wready) begin
        wvalid <= 1'b0;
        w_acc  <= 1'b1;
      end
      if (wr_done) pend <= 1'b0;
    end
  end

endmodule

// File: rtl/fir_cfg_seq.sv
// AXI-Lite master that loads data_length and taps into the FIR, starts it,
// and polls ap_ctrl until done or until the poll budget runs out.
module fir_cfg_seq
  import fir_pkg::*;
#(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = 11,
  parameter int POLL_GAP    = 4,
  parameter int POLL_MAX    = 256
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [pDATA_WIDTH-1:0] cmd_len,
  input  logic                   coef_valid,
  output logic                   coef_ready,
  input  logic [pDATA_WIDTH-1:0] coef_data,
  output logic                   awvalid,
  input  logic                   awready,
  output logic [pADDR_WIDTH-1:0] awaddr,
  output logic                   wvalid,
  input  logic                   wready,
  output logic [pDATA_WIDTH-1:0] wdata,
  output logic                   arvalid,
  input  logic                   arready,
  output logic [pADDR_WIDTH-1:0] araddr,
  input  logic                   rvalid,
  output logic                   rready,
  input  logic [pDATA_WIDTH-1:0] rdata,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int IDX_W  = $clog2(Tape_Num + 1);
  localparam int PCNT_W = $clog2(POLL_MAX + 1);
  localparam int GAP_W  = $clog2(POLL_GAP + 1);

  seq_state_t state, next_state;
  logic [IDX_W-1:0]  idx, idx_inc;
  logic [PCNT_W-1:0] pcnt, pcnt_inc;
  logic [GAP_W-1:0]  gap;

  logic                   cmd_hs;
  logic                   wr_start, wr_pend, wr_done;
  logic [pADDR_WIDTH-1:0] wr_addr;
  logic [pDATA_WIDTH-1:0] wr_data;
  logic                   rdata_unused;

  assign cmd_ready  = (state == IDLE) && !axis_rst;
  assign coef_ready = (state == TAP_GET);
  assign rready     = (state == POLL_R);
  assign cmd_hs     = cmd_valid && cmd_ready;
  assign idx_inc    = idx + 1'b1;
  assign pcnt_inc   = pcnt + 1'b1;

  // Only the done bit steers the sequence; idle and start are ignored on read.
  assign rdata_unused = ^{rdata[pDATA_WIDTH-1:AP_IDLE_BIT+1], rdata[AP_IDLE_BIT],
                          rdata[AP_START_BIT]};

  // Writes are launched on the edge that enters or sits in a write state, so
  // the valids appear one cycle after the triggering handshake.
  always_comb begin
    wr_start = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    case (state)
      IDLE: begin
        if (cmd_hs) begin
          wr_start = 1'b1;
          wr_addr  = pADDR_WIDTH'(ADDR_DATA_LEN);
          wr_data  = cmd_len;
        end
      end
      TAP_GET: begin
        if (coef_valid) begin
          wr_start = 1'b1;
          wr_addr  = pADDR_WIDTH'(ADDR_TAP_BASE) + (pADDR_WIDTH'(idx) << 2);
          wr_data  = coef_data;
        end
      end
      WR_START: begin
        if (!wr_pend) begin
          wr_start              = 1'b1;
          wr_addr               = pADDR_WIDTH'(ADDR_AP_CTRL);
          wr_data[AP_START_BIT] = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (cmd_hs) next_state = WR_LEN;
      WR_LEN:    if (wr_done) next_state = TAP_GET;
      TAP_GET:   if (coef_valid) next_state = TAP_WR;
      TAP_WR: begin
        if (wr_done)
          next_state = (idx_inc < IDX_W'(Tape_Num)) ? TAP_GET : WR_START;
      end
      WR_START:  if (wr_done) next_state = POLL_AR;
      POLL_AR:   if (arready) next_state = POLL_R;
      POLL_R: begin
        if (rvalid) begin
          if (rdata[AP_DONE_BIT])              next_state = DONE;
          else if (pcnt_inc == PCNT_W'(POLL_MAX)) next_state = ERR;
          else                                 next_state = POLL_WAIT;
        end
      end
      POLL_WAIT: if (gap == '0) next_state = POLL_AR;
      DONE:      next_state = IDLE;
      ERR:       next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      state   <= IDLE;
      idx     <= '0;
      pcnt    <= '0;
      gap     <= '0;
      arvalid <= 1'b0;
      araddr  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= next_state;
      arvalid <= (next_state == POLL_AR);
      araddr  <= pADDR_WIDTH'(ADDR_AP_CTRL);
      busy    <= (next_state != IDLE);
      done    <= (next_state == DONE);
      err     <= (next_state == ERR);
      case (state)
        IDLE: begin
          if (cmd_hs) begin
            idx  <= '0;
            pcnt <= '0;
          end
        end
        TAP_WR: if (wr_done) idx <= idx_inc;
        POLL_R: begin
          if (rvalid && !rdata[AP_DONE_BIT]) begin
            pcnt <= pcnt_inc;
            gap  <= GAP_W'(POLL_GAP - 1);
          end
        end
        POLL_WAIT: if (gap != '0) gap <= gap - 1'b1;
        default: ;
      endcase
    end
  end

  axil_wr_ch #(
    .AW(pADDR_WIDTH),
    .DW(pDATA_WIDTH)
  ) u_wr (
    .clk     (axis_clk),
    .rst     (axis_rst),
    .start   (wr_start),
    .addr    (wr_addr),
    .data    (wr_data),
    .awvalid (awvalid),
    .awready (awready),
    .awaddr  (awaddr),
    .wvalid  (wvalid),
    .wready  (wready),
    .wdata   (wdata),
    .pend    (wr_pend),
    .wr_done (wr_done)
  );

endmodule

// File: tb/tb_fir_cfg_seq.sv
// Drives commands/coefficients into fir_cfg_seq against a behavioural FIR
// slave and checks write order, handshake rules and poll outcome.
module tb_fir_cfg_seq;

  localparam int AW       = 12;
  localparam int DW       = 32;
  localparam int TAPS     = 11;
  localparam int POLL_GAP = 4;
  localparam int POLL_MAX = 8;
  localparam int BUD      = 200;

  logic          clk, rst;
  logic          cmd_valid, cmd_ready;
  logic [DW-1:0] cmd_len;
  logic          coef_valid, coef_ready;
  logic [DW-1:0] coef_data;
  logic          awvalid, awready, wvalid, wready;
  logic [AW-1:0] awaddr, araddr;
  logic [DW-1:0] wdata, rdata;
  logic          arvalid, arready, rvalid, rready;
  logic          busy, done, err;

  fir_cfg_seq #(
    .pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .Tape_Num(TAPS),
    .POLL_GAP(POLL_GAP), .POLL_MAX(POLL_MAX)
  ) dut (
    .axis_clk(clk), .axis_rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .coef_valid(coef_valid), .coef_ready(coef_ready), .coef_data(coef_data),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata),
    .busy(busy), .done(done), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- write slave: per-transaction ready delays --------------
  logic [31:0] aw_q[$], wd_q[$];
  logic [15:0] dly_q[$];
  bit          rand_dly = 0;

  initial begin : wr_slave
    int aw_cnt, w_cnt, aw_dly, w_dly;
    bit in_tx;
    awready = 0; wready = 0; in_tx = 0;
    aw_cnt = 0; w_cnt = 0; aw_dly = 0; w_dly = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        awready = 0; wready = 0; in_tx = 0; aw_cnt = 0; w_cnt = 0;
        continue;
      end
      if (!awvalid && !wvalid) in_tx = 0;
      if ((awvalid || wvalid) && !in_tx) begin
        in_tx = 1; aw_cnt = 0; w_cnt = 0;
        if (dly_q.size() > 0) begin
          aw_dly = int'(dly_q[0][15:8]);
          w_dly  = int'(dly_q[0][7:0]);
          void'(dly_q.pop_front());
        end else if (rand_dly) begin
          aw_dly = $urandom_range(0, 3);
          w_dly  = $urandom_range(0, 3);
        end else begin
          aw_dly = 0; w_dly = 0;
        end
      end
      awready = awvalid && (aw_cnt >= aw_dly);
      wready  = wvalid && (w_cnt >= w_dly);
      if (awvalid && awready) aw_q.push_back(32'(awaddr));
      if (wvalid && wready)   wd_q.push_back(wdata);
      if (awvalid) aw_cnt++;
      if (wvalid)  w_cnt++;
    end
  end

  // ---------------- read slave: zero-wait, scripted status ---------------
  logic [31:0] stat_q[$];
  logic [31:0] stat_dflt = 0;
  int          ar_cyc_q[$];
  int          last_r_cyc = 0;

  initial begin : rd_slave
    bit ar_fire, r_fire;
    arready = 0; rvalid = 0; rdata = 0; ar_fire = 0; r_fire = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        arready = 0; rvalid = 0; rdata = 0; ar_fire = 0; r_fire = 0;
        continue;
      end
      if (r_fire) begin rvalid = 0; r_fire = 0; end
      if (ar_fire) begin
        rvalid = 1;
        rdata  = (stat_q.size() > 0) ? stat_q.pop_front() : stat_dflt;
        ar_fire = 0;
      end
      arready = 1;
      if (arvalid && arready) begin ar_fire = 1; ar_cyc_q.push_back(cyc); end
      if (rvalid && rready) begin r_fire = 1; last_r_cyc = cyc; end
    end
  end

  // ---------------- write-channel protocol observer ----------------------
  int rise_viol = 0, gap_viol = 0, stab_viol = 0;

  initial begin : wr_mon
    bit aw_prev, w_prev, aw_rise, w_rise;
    int idle_run;
    logic [AW-1:0] cap_a;
    logic [DW-1:0] cap_d;
    aw_prev = 0; w_prev = 0; idle_run = 2; cap_a = '0; cap_d = '0;
    forever begin
      @(negedge clk);
      if (rst) begin aw_prev = 0; w_prev = 0; idle_run = 2; continue; end
      aw_rise = awvalid && !aw_prev;
      w_rise  = wvalid && !w_prev;
      if (aw_rise != w_rise) rise_viol++;
      if ((aw_rise || w_rise) && idle_run < 1) gap_viol++;
      if (aw_rise) cap_a = awaddr; else if (awvalid && awaddr !== cap_a) stab_viol++;
      if (w_rise)  cap_d = wdata;  else if (wvalid && wdata !== cap_d) stab_viol++;
      if (awvalid || wvalid) idle_run = 0; else idle_run++;
      aw_prev = awvalid; w_prev = wvalid;
    end
  end

  // ---------------- reference model for the poll outcome ----------------
  function automatic void model_poll(input logic [31:0] st[$], input logic [31:0] dflt,
                                     output int polls, output bit is_done);
    logic [31:0] s;
    polls = POLL_MAX;
    is_done = 0;
    for (int i = 0; i < POLL_MAX; i++) begin
      s = (i < st.size()) ? st[i] : dflt;
      if (s[1]) begin
        polls = i + 1;
        is_done = 1;
        return;
      end
    end
  endfunction

  task automatic wait_cmd_ready(input string tag);
    int n = 0;
    while (!cmd_ready && n < BUD) begin @(negedge clk); n++; end
    chk(tag, 32'(n < BUD), 1);
  endtask

  task automatic wait_coef_ready(input string tag);
    int n = 0;
    while (!coef_ready && n < BUD) begin @(negedge clk); n++; end
    chk(tag, 32'(n < BUD), 1);
  endtask

  task automatic run_cmd(input logic [31:0] len, input logic [31:0] coefs[$],
                         input int stall_at, input int abort_at,
                         input logic [31:0] st[$], input logic [31:0] dflt);
    logic [31:0] exp_a[$], exp_d[$];
    int  polls, n;
    bit  exp_done;
    exp_a.push_back(32'h10); exp_d.push_back(len);
    foreach (coefs[i]) begin
      exp_a.push_back(32'h20 + 4 * i);
      exp_d.push_back(coefs[i]);
    end
    exp_a.push_back(32'h00); exp_d.push_back(32'h1);
    model_poll(st, dflt, polls, exp_done);
    aw_q.delete(); wd_q.delete(); ar_cyc_q.delete();
    stat_q = st; stat_dflt = dflt;
    rise_viol = 0; gap_viol = 0; stab_viol = 0;

    cmd_valid = 1; cmd_len = len;
    wait_cmd_ready("cmd_hs_timeout");
    @(negedge clk);
    cmd_valid = 0; cmd_len = $urandom;
    chk("len_valids", {30'd0, awvalid, wvalid}, 32'h3);
    chk("len_addr", 32'(awaddr), 32'h10);
    chk("len_data", wdata, len);
    chk("busy_after_cmd", 32'(busy), 1);

    for (int i = 0; i < coefs.size(); i++) begin
      if (i == stall_at) begin
        wait_coef_ready("stall_ready_timeout");
        for (int s = 0; s < 5; s++) begin
          chk("stall_coef_ready", 32'(coef_ready), 1);
          chk("stall_no_write", {30'd0, awvalid, wvalid}, 0);
          @(negedge clk);
        end
      end
      coef_valid = 1; coef_data = coefs[i];
      wait_coef_ready("coef_hs_timeout");
      @(negedge clk);
      coef_valid = 0; coef_data = $urandom;
      chk("tap_valids", {30'd0, awvalid, wvalid}, 32'h3);
      chk("tap_addr", 32'(awaddr), 32'h20 + 4 * i);
      chk("tap_data", wdata, coefs[i]);
      if (i == abort_at) begin
        #2 rst = 1;
        #1;
        chk("rst_awvalid", 32'(awvalid), 0);
        chk("rst_wvalid", 32'(wvalid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_coef_ready", 32'(coef_ready), 0);
        chk("rst_cmd_ready", 32'(cmd_ready), 0);
        chk("rst_awaddr", 32'(awaddr), 0);
        @(negedge clk);
        #2 rst = 0;
        aw_q.delete(); wd_q.delete(); ar_cyc_q.delete(); dly_q.delete();
        @(negedge clk);
        chk("rel_cmd_ready", 32'(cmd_ready), 1);
        return;
      end
    end

    n = 0;
    while (!done && !err && n < BUD * 4) begin @(negedge clk); n++; end
    chk("outcome_timeout", 32'(n < BUD * 4), 1);
    chk("done_pulse", 32'(done), 32'(exp_done));
    chk("err_pulse", 32'(err), 32'(!exp_done));
    chk("busy_during_end", 32'(busy), 1);
    chk("end_latency", 32'(cyc), 32'(last_r_cyc + 1));
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 0);
    chk("err_one_cycle", 32'(err), 0);
    chk("busy_falls", 32'(busy), 0);
    chk("idle_cmd_ready", 32'(cmd_ready), 1);

    chk("n_aw", 32'(aw_q.size()), 32'(exp_a.size()));
    chk("n_w", 32'(wd_q.size()), 32'(exp_d.size()));
    for (int i = 0; i < exp_a.size() && i < aw_q.size() && i < wd_q.size(); i++) begin
      chk("wr_addr", aw_q[i], exp_a[i]);
      chk("wr_data", wd_q[i], exp_d[i]);
    end
    chk("n_polls", 32'(ar_cyc_q.size()), 32'(polls));
    for (int i = 1; i < ar_cyc_q.size(); i++)
      chk("poll_spacing", 32'(ar_cyc_q[i] - ar_cyc_q[i-1]), 32'(2 + POLL_GAP));
    chk("aw_w_rise_together", 32'(rise_viol), 0);
    chk("idle_between_writes", 32'(gap_viol), 0);
    chk("addr_data_stable", 32'(stab_viol), 0);
  endtask

  logic [31:0] coefs[$];
  logic [31:0] st[$];

  initial begin
    rst = 1; cmd_valid = 0; cmd_len = 0; coef_valid = 0; coef_data = 0;
    repeat (3) @(negedge clk);
    chk("reset_cmd_ready", 32'(cmd_ready), 0);
    chk("reset_valids", {28'd0, awvalid, wvalid, arvalid, busy}, 0);
    chk("reset_pulses", {30'd0, done, err}, 0);
    chk("reset_awaddr", 32'(awaddr), 0);
    chk("reset_araddr", 32'(araddr), 0);
    chk("reset_wdata", wdata, 0);
    #2 rst = 0;
    @(negedge clk);
    chk("first_cmd_ready", 32'(cmd_ready), 1);

    // zero-wait slave, ramp coefficients, done on the fourth poll
    coefs.delete();
    for (int i = 0; i < TAPS; i++) coefs.push_back(32'(i));
    st = {32'h0, 32'h0, 32'h0, 32'h2};
    run_cmd(32'd64, coefs, -1, -1, st, 32'h0);

    // skewed readies, coefficient stall, done+idle both set on poll two
    dly_q = {16'h0003, 16'h0300, 16'h0202};
    rand_dly = 1;
    coefs.delete();
    for (int i = 0; i < TAPS; i++) coefs.push_back($urandom);
    st = {32'h4, 32'h6};
    run_cmd($urandom, coefs, 4, -1, st, 32'h0);

    // zero length, status never done -> timeout after POLL_MAX polls
    rand_dly = 0;
    coefs.delete();
    for (int i = 0; i < TAPS; i++) coefs.push_back($urandom);
    st.delete();
    run_cmd(32'd0, coefs, -1, -1, st, 32'h4);

    // reset during a tap write, then a clean command from the top
    coefs.delete();
    for (int i = 0; i < TAPS; i++) coefs.push_back($urandom);
    st.delete();
    run_cmd($urandom, coefs, -1, 2, st, 32'h2);
    rand_dly = 1;
    coefs.delete();
    for (int i = 0; i < TAPS; i++) coefs.push_back($urandom);
    st = {32'h1, 32'h0, 32'h2};
    run_cmd($urandom, coefs, -1, -1, st, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fir_cfg_seq.md
# fir_cfg_seq

AXI-Lite master sequencer that configures and launches the `fir` engine without processor involvement. On a command it writes `data_length`, streams in `Tape_Num` coefficients and writes them to the tap region. It then sets `ap_start` and polls `ap_ctrl` until `ap_done`, reporting completion or timeout. It sits between the testbench/host command source and the FIR's AXI-Lite slave port.

## Interface
- `pADDR_WIDTH`, 12, AXI-Lite address width
- `pDATA_WIDTH`, 32, data width
- `Tape_Num`, 11, number of coefficients written per command
- `POLL_GAP`, 4, idle cycles between status polls (≥1)
- `POLL_MAX`, 256, polls before timeout (≥1)

Ports:
- `axis_clk`  in  1  clock
- `axis_rst`  in  1  asynchronous, active-high reset
- `cmd_valid` / `cmd_ready`  in / out  1  command handshake
- `cmd_len`  in  32  data length, latched on command handshake
- `coef_valid` / `coef_ready`  in / out  1  coefficient stream handshake
- `coef_data`  in  32  coefficient
- `awvalid` / `awready`  out / in  1  write-address handshake
- `awaddr`  out  pADDR_WIDTH  write address
- `wvalid` / `wready`  out / in  1  write-data handshake
- `wdata`  out  32  write data
- `arvalid` / `arready`  out / in  1  read-address handshake
- `araddr`  out  pADDR_WIDTH  read address
- `rvalid` / `rready`  in / out  1  read-data handshake
- `rdata`  in  32  read data
- `busy`  out  1  high in any state except IDLE
- `done`  out  1  one-cycle pulse on `ap_done` seen
- `err`  out  1  one-cycle pulse on poll timeout

## Operation
- Address map:
  - 0x00: `ap_ctrl`; bit0 start, bit1 done, bit2 idle.
  - 0x10: `data_length`.
  - 0x20+4·i: tap i.
- States: IDLE → WR_LEN → TAP_GET ⇄ TAP_WR → WR_START → POLL_AR → POLL_R → (POLL_WAIT → POLL_AR) → DONE / ERR → IDLE.
- **IDLE:** `cmd_ready`=1. On `cmd_valid&cmd_ready`: latch `cmd_len`, clear tap index and poll count, go to WR_LEN.
- **WR_LEN:** write `cmd_len` to 0x10.
- **TAP_GET:** `coef_ready`=1. On handshake, register `coef_data` into `wdata` and `awaddr`=0x20+4·idx, then go to TAP_WR.
- **TAP_WR:** perform the write and increment idx. After the write completes, go to TAP_GET if idx<Tape_Num, else WR_START.
- **WR_START:** write 0x00000001 to 0x00.
- **POLL_AR:** `arvalid`=1, `araddr`=0. On `arready`, go to POLL_R.
- **POLL_R:** `rready`=1. On `rvalid`:
  - if `rdata[1]`, go to DONE (done has priority over bit2);
  - else increment poll count; if poll count = POLL_MAX go to ERR, else go to POLL_WAIT for POLL_GAP cycles, then POLL_AR.
- **DONE / ERR:** each lasts one cycle, pulses `done` / `err` respectively, then IDLE.
- **Write rule:**
  - `awvalid` and `wvalid` rise together; each is held until its own ready is sampled high, then drops independently.
  - Per-channel accepted flags are kept; the write is complete when both flags are set, including the case where both readies arrive in the same cycle.
  - `awaddr` and `wdata` are stable while the corresponding valid is high.
- `cmd_len`=0 is written unchanged; no special case.
- Tap index counter is `$clog2(Tape_Num+1)` bits; poll counter is `$clog2(POLL_MAX+1)` bits; neither wraps.

## Timing
- All outputs are registered except `cmd_ready`, `coef_ready` and `rready`, which are state decodes.
- Reset values: all valids, `done`, `err`, `busy` = 0; `awaddr`, `araddr`, `wdata` = 0; state = IDLE.
- `cmd_ready` is 0 while `axis_rst`=1 and 1 in the first cycle after release.
- Command handshake at edge k → `awvalid`/`wvalid` high from k+1 with 0x10.
- Write completion at edge m → valids low at m+1; the next transaction's valids rise no earlier than m+2, giving at least one idle cycle between transactions.
- Coefficient handshake at edge c → tap write valids high from c+1.
- Poll: with zero-wait slaves, 1 cycle `arvalid`, ≥1 cycle `rready`, then POLL_GAP idle cycles.
- `done` / `err` assert the cycle after the deciding `rvalid` edge, for exactly one cycle.
- `axis_rst` mid-operation: the outstanding transaction is abandoned and all outputs take their reset values immediately. The FIR side is reset by its own reset.

## Structure
- Shared package `fir_pkg`:
  - address constants `ADDR_AP_CTRL`=0x00, `ADDR_DATA_LEN`=0x10, `ADDR_TAP_BASE`=0x20;
  - `ap_ctrl` bit indices;
  - state enum.
- One natural sub-module: `axil_wr_ch`. It issues a single AXI-Lite write with independent aw/w acceptance flags and a `wr_done` pulse, and is reused for every write state.

## Test plan
- Zero-wait FIR slave, `cmd_len`=64, coefs 0..10 → writes in order: 0x10←64, 0x20..0x48←0..10, 0x00←1. Minimum one idle cycle between writes.
- `awready` 3 cycles before `wready`, then the reverse, then both in the same cycle → each write issued exactly once; `wdata`/`awaddr` stable until accepted.
- `coef_valid` low for 5 cycles between tap 3 and tap 4 → `coef_ready` stays high, no write is issued during the stall, and tap 4 lands at 0x30.
- Status reads return 0x0 ×3 then 0x2 → 4 polls separated by POLL_GAP=4 idle cycles; `done` pulses 1 cycle; `busy` falls with it.
- POLL_MAX=8, status always 0x4 → 8 polls, then an `err` pulse, then IDLE with `cmd_ready`=1.
- `axis_rst` asserted mid tap write → `awvalid`/`wvalid`=0 and `busy`=0 at once. A new command after release restarts from the 0x10 write.
